// File: rtl/ex_pkg.sv
// Shared ALU opcodes, forwarding-select encoding and the ID/EX control bundle.
// Imported by the ID/EX stage and its forwarding unit.
package ex_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_EQ  = 4'b1000;
  localparam logic [3:0] ALU_NE  = 4'b1110;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // Single-bit control carried from ID into EX; the opcode lives beside it
  // because its width is a parameter of the stage.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src;
  } ex_ctrl_t;

endpackage

// File: rtl/forward_unit.sv
// Combinational operand-source select for one register index; MEM beats WB, x0 never forwards.
// Zero latency, no flow control.
module forward_unit
  import ex_pkg::*;
#(
  parameter int REG_ADDR = 5
) (
  input  logic [REG_ADDR-1:0] i_rs,
  input  logic [REG_ADDR-1:0] i_mem_rd,
  input  logic                i_mem_reg_write,
  input  logic [REG_ADDR-1:0] i_wb_rd,
  input  logic                i_wb_reg_write,
  output fwd_sel_e            o_sel
);

  always_comb begin
    o_sel = FWD_REG;
    if (i_rs != '0) begin
      if (i_mem_reg_write && (i_mem_rd == i_rs)) begin
        o_sel = FWD_MEM;
      end else if (i_wb_reg_write && (i_wb_rd == i_rs)) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register feeding the ALU; 1-cycle ID->EX latency, Stall freezes IF/ID while a bubble enters EX.
// ID_EX_FORWARDING_EN selects forwarding muxes plus load-use stall; without it Stall covers EX and MEM producers.
module id_ex_stage
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     IdValid,
  input  logic [REG_ADDR-1:0]      IdRs1,
  input  logic [REG_ADDR-1:0]      IdRs2,
  input  logic [REG_ADDR-1:0]      IdRd,
  input  logic [DATA_WIDTH-1:0]    IdRs1Data,
  input  logic [DATA_WIDTH-1:0]    IdRs2Data,
  input  logic [DATA_WIDTH-1:0]    IdImm,
  input  logic                     IdALUSrc,
  input  logic [OPCODE_LENGTH-1:0] IdALUOp,
  input  logic                     IdRegWrite,
  input  logic                     IdMemRead,
  input  logic                     IdMemWrite,
  input  logic                     Flush,
  input  logic                     Hold,
  input  logic [REG_ADDR-1:0]      MemRd,
  input  logic                     MemRegWrite,
  input  logic [DATA_WIDTH-1:0]    MemResult,
  input  logic [REG_ADDR-1:0]      WbRd,
  input  logic                     WbRegWrite,
  input  logic [DATA_WIDTH-1:0]    WbData,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    ExStoreData,
  output logic                     ExValid,
  output logic                     ExRegWrite,
  output logic                     ExMemRead,
  output logic                     ExMemWrite,
  output logic [REG_ADDR-1:0]      ExRd,
  output logic                     Stall
);

  ex_ctrl_t                 r_ctrl;
  logic [OPCODE_LENGTH-1:0] r_alu_op;
  logic [REG_ADDR-1:0]      r_rs1;
  logic [REG_ADDR-1:0]      r_rs2;
  logic [REG_ADDR-1:0]      r_rd;
  logic [DATA_WIDTH-1:0]    r_rs1_data;
  logic [DATA_WIDTH-1:0]    r_rs2_data;
  logic [DATA_WIDTH-1:0]    r_imm;

  logic                     w_stall;
  logic [DATA_WIDTH-1:0]    w_rs1_fwd;
  logic [DATA_WIDTH-1:0]    w_rs2_fwd;
  fwd_sel_e                 w_sel1;
  fwd_sel_e                 w_sel2;

  // Reset, flush and bubble all collapse to the same cleared state.
  always_ff @(posedge clk) begin
    if (!reset || Flush || w_stall) begin
      r_ctrl     <= '0;
      r_alu_op   <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
    end else if (!Hold) begin
      r_ctrl.valid     <= IdValid;
      r_ctrl.reg_write <= IdRegWrite;
      r_ctrl.mem_read  <= IdMemRead;
      r_ctrl.mem_write <= IdMemWrite;
      r_ctrl.alu_src   <= IdALUSrc;
      r_alu_op         <= IdALUOp;
      r_rs1            <= IdRs1;
      r_rs2            <= IdRs2;
      r_rd             <= IdRd;
      r_rs1_data       <= IdRs1Data;
      r_rs2_data       <= IdRs2Data;
      r_imm            <= IdImm;
    end
  end

  assign ExValid    = r_ctrl.valid;
  assign ExRegWrite = r_ctrl.valid & r_ctrl.reg_write;
  assign ExMemRead  = r_ctrl.valid & r_ctrl.mem_read;
  assign ExMemWrite = r_ctrl.valid & r_ctrl.mem_write;
  assign ExRd       = r_rd;
  assign Operation  = r_alu_op;
  assign Stall      = w_stall;

  assign SrcA        = w_rs1_fwd;
  assign SrcB        = r_ctrl.alu_src ? r_imm : w_rs2_fwd;
  assign ExStoreData = w_rs2_fwd;

`ifdef ID_EX_FORWARDING_EN

  forward_unit #(.REG_ADDR(REG_ADDR)) u_fwd_rs1 (
    .i_rs           (r_rs1),
    .i_mem_rd       (MemRd),
    .i_mem_reg_write(MemRegWrite),
    .i_wb_rd        (WbRd),
    .i_wb_reg_write (WbRegWrite),
    .o_sel          (w_sel1)
  );

  forward_unit #(.REG_ADDR(REG_ADDR)) u_fwd_rs2 (
    .i_rs           (r_rs2),
    .i_mem_rd       (MemRd),
    .i_mem_reg_write(MemRegWrite),
    .i_wb_rd        (WbRd),
    .i_wb_reg_write (WbRegWrite),
    .o_sel          (w_sel2)
  );

  always_comb begin
    w_rs1_fwd = r_rs1_data;
    case (w_sel1)
      FWD_MEM: w_rs1_fwd = MemResult;
      FWD_WB:  w_rs1_fwd = WbData;
      default: w_rs1_fwd = r_rs1_data;
    endcase
  end

  always_comb begin
    w_rs2_fwd = r_rs2_data;
    case (w_sel2)
      FWD_MEM: w_rs2_fwd = MemResult;
      FWD_WB:  w_rs2_fwd = WbData;
      default: w_rs2_fwd = r_rs2_data;
    endcase
  end

  // Only a load in EX cannot be forwarded in time; everything else is covered by the muxes.
  assign w_stall = !Hold && IdValid && ExMemRead && (r_rd != '0) &&
                   ((r_rd == IdRs1) || (r_rd == IdRs2));

`else

  logic w_ex_hit;
  logic w_mem_hit;
  logic w_unused;

  // The forwarding units double as MEM-stage hazard comparators on the ID indices.
  forward_unit #(.REG_ADDR(REG_ADDR)) u_fwd_rs1 (
    .i_rs           (IdRs1),
    .i_mem_rd       (MemRd),
    .i_mem_reg_write(MemRegWrite),
    .i_wb_rd        ('0),
    .i_wb_reg_write (1'b0),
    .o_sel          (w_sel1)
  );

  forward_unit #(.REG_ADDR(REG_ADDR)) u_fwd_rs2 (
    .i_rs           (IdRs2),
    .i_mem_rd       (MemRd),
    .i_mem_reg_write(MemRegWrite),
    .i_wb_rd        ('0),
    .i_wb_reg_write (1'b0),
    .o_sel          (w_sel2)
  );

  assign w_rs1_fwd = r_rs1_data;
  assign w_rs2_fwd = r_rs2_data;

  assign w_ex_hit  = ExRegWrite && (r_rd != '0) &&
                     ((r_rd == IdRs1) || (r_rd == IdRs2));
  assign w_mem_hit = (w_sel1 == FWD_MEM) || (w_sel2 == FWD_MEM);
  assign w_stall   = !Hold && IdValid && (w_ex_hit || w_mem_hit);

  // WB is resolved by register-file write-before-read, so these go unobserved here.
  assign w_unused = ^{MemResult, WbData, WbRd, WbRegWrite, r_rs1, r_rs2};

`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expectations follow ID_EX_FORWARDING_EN when defined.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        IdValid;
  logic [4:0]  IdRs1, IdRs2, IdRd;
  logic [31:0] IdRs1Data, IdRs2Data, IdImm;
  logic        IdALUSrc;
  logic [3:0]  IdALUOp;
  logic        IdRegWrite, IdMemRead, IdMemWrite;
  logic        Flush, Hold;
  logic [4:0]  MemRd;
  logic        MemRegWrite;
  logic [31:0] MemResult;
  logic [4:0]  WbRd;
  logic        WbRegWrite;
  logic [31:0] WbData;
  logic [31:0] SrcA, SrcB, ExStoreData;
  logic [3:0]  Operation;
  logic        ExValid, ExRegWrite, ExMemRead, ExMemWrite;
  logic [4:0]  ExRd;
  logic        Stall;

  int checks = 0;
  int errors = 0;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .IdValid(IdValid),
    .IdRs1(IdRs1), .IdRs2(IdRs2), .IdRd(IdRd),
    .IdRs1Data(IdRs1Data), .IdRs2Data(IdRs2Data), .IdImm(IdImm),
    .IdALUSrc(IdALUSrc), .IdALUOp(IdALUOp),
    .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead), .IdMemWrite(IdMemWrite),
    .Flush(Flush), .Hold(Hold),
    .MemRd(MemRd), .MemRegWrite(MemRegWrite), .MemResult(MemResult),
    .WbRd(WbRd), .WbRegWrite(WbRegWrite), .WbData(WbData),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ExStoreData(ExStoreData),
    .ExValid(ExValid), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
    .ExMemWrite(ExMemWrite), .ExRd(ExRd), .Stall(Stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic alusrc, input logic [3:0] op,
                        input logic rw, input logic mr, input logic mw);
    IdValid = v; IdRs1 = rs1; IdRs2 = rs2; IdRd = rd;
    IdRs1Data = d1; IdRs2Data = d2; IdImm = imm; IdALUSrc = alusrc;
    IdALUOp = op; IdRegWrite = rw; IdMemRead = mr; IdMemWrite = mw;
  endtask

  task automatic clear_fwd();
    MemRd = 5'd0; MemRegWrite = 1'b0; MemResult = 32'h0;
    WbRd = 5'd0; WbRegWrite = 1'b0; WbData = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0; Flush = 1'b0; Hold = 1'b0;
    clear_fwd();
    set_id(1, 1, 2, 3, 32'h5, 32'h7, 32'h0, 0, 4'b0010, 1, 1, 1);
    tick(); tick();
    checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL reset_exvalid got %0h want 0", ExValid); end
    checks++; if (ExRegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %0h want 0", ExRegWrite); end
    checks++; if (ExMemRead !== 1'b0) begin errors++; $display("FAIL reset_memread got %0h want 0", ExMemRead); end
    checks++; if (ExMemWrite !== 1'b0) begin errors++; $display("FAIL reset_memwrite got %0h want 0", ExMemWrite); end
    checks++; if (Operation !== 4'b0000) begin errors++; $display("FAIL reset_op got %0h want 0", Operation); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0h want 0", Stall); end
    checks++; if (SrcA !== 32'h0) begin errors++; $display("FAIL reset_srca got %0h want 0", SrcA); end
    checks++; if (ExRd !== 5'd0) begin errors++; $display("FAIL reset_exrd got %0h want 0", ExRd); end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    set_id(1, 1, 2, 3, 32'h5, 32'h7, 32'h0, 0, 4'b0010, 1, 0, 0);
    tick();
    checks++; if (ExValid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0h want 1", ExValid); end
    checks++; if (ExRegWrite !== 1'b1) begin errors++; $display("FAIL basic_regwrite got %0h want 1", ExRegWrite); end
    checks++; if (ExRd !== 5'd3) begin errors++; $display("FAIL basic_exrd got %0d want 3", ExRd); end
    checks++; if (Operation !== 4'b0010) begin errors++; $display("FAIL basic_op got %0h want 2", Operation); end
    checks++; if (SrcA !== 32'h5) begin errors++; $display("FAIL basic_srca got %0h want 5", SrcA); end
    checks++; if (SrcB !== 32'h7) begin errors++; $display("FAIL basic_srcb got %0h want 7", SrcB); end
    set_id(1, 1, 2, 6, 32'h5, 32'h7, 32'h100, 1, 4'b0000, 1, 0, 1);
    tick();
    checks++; if (SrcB !== 32'h100) begin errors++; $display("FAIL imm_srcb got %0h want 100", SrcB); end
    checks++; if (ExStoreData !== 32'h7) begin errors++; $display("FAIL imm_store got %0h want 7", ExStoreData); end
    checks++; if (ExMemWrite !== 1'b1) begin errors++; $display("FAIL imm_memwrite got %0h want 1", ExMemWrite); end
  endtask

  task automatic test_forward();
    set_id(1, 3, 1, 4, 32'h99, 32'h5, 32'h0, 0, 4'b0110, 1, 0, 0);
    tick();
    MemRd = 5'd3; MemRegWrite = 1'b1; MemResult = 32'h10; #1;
    checks++; if (SrcA !== (FWD ? 32'h10 : 32'h99)) begin errors++; $display("FAIL fwd_mem got %0h want %0h", SrcA, FWD ? 32'h10 : 32'h99); end
    checks++; if (Operation !== 4'b0110) begin errors++; $display("FAIL fwd_op got %0h want 6", Operation); end
    WbRd = 5'd3; WbRegWrite = 1'b1; WbData = 32'h20; #1;
    checks++; if (SrcA !== (FWD ? 32'h10 : 32'h99)) begin errors++; $display("FAIL fwd_mem_prio got %0h want %0h", SrcA, FWD ? 32'h10 : 32'h99); end
    MemRegWrite = 1'b0; #1;
    checks++; if (SrcA !== (FWD ? 32'h20 : 32'h99)) begin errors++; $display("FAIL fwd_wb got %0h want %0h", SrcA, FWD ? 32'h20 : 32'h99); end
    MemRegWrite = 1'b1; WbRd = 5'd1; WbData = 32'h55; #1;
    checks++; if (SrcA !== (FWD ? 32'h10 : 32'h99)) begin errors++; $display("FAIL fwd_split_a got %0h want %0h", SrcA, FWD ? 32'h10 : 32'h99); end
    checks++; if (ExStoreData !== (FWD ? 32'h55 : 32'h5)) begin errors++; $display("FAIL fwd_split_store got %0h want %0h", ExStoreData, FWD ? 32'h55 : 32'h5); end
    checks++; if (SrcB !== (FWD ? 32'h55 : 32'h5)) begin errors++; $display("FAIL fwd_split_b got %0h want %0h", SrcB, FWD ? 32'h55 : 32'h5); end
    clear_fwd();
  endtask

  task automatic test_zero_reg();
    set_id(1, 0, 0, 8, 32'h0, 32'h0, 32'h0, 0, 4'b0010, 1, 0, 0);
    tick();
    MemRd = 5'd0; MemRegWrite = 1'b1; MemResult = 32'hFFFF_FFFF;
    WbRd = 5'd0; WbRegWrite = 1'b1; WbData = 32'hDEAD; #1;
    checks++; if (SrcA !== 32'h0) begin errors++; $display("FAIL x0_srca got %0h want 0", SrcA); end
    checks++; if (SrcB !== 32'h0) begin errors++; $display("FAIL x0_srcb got %0h want 0", SrcB); end
    clear_fwd();
  endtask

  task automatic test_load_use();
    set_id(1, 1, 0, 5, 32'h100, 32'h0, 32'h4, 1, 4'b0010, 1, 1, 0);
    tick();
    set_id(1, 5, 2, 6, 32'h1111, 32'h7, 32'h0, 0, 4'b0010, 1, 0, 0); #1;
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0h want 1", Stall); end
    tick();
    checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL lu_bubble_valid got %0h want 0", ExValid); end
    checks++; if (ExMemRead !== 1'b0) begin errors++; $display("FAIL lu_bubble_memread got %0h want 0", ExMemRead); end
    checks++; if (Operation !== 4'b0000) begin errors++; $display("FAIL lu_bubble_op got %0h want 0", Operation); end
    MemRd = 5'd5; MemRegWrite = 1'b1; #1;
    checks++; if (Stall !== !FWD) begin errors++; $display("FAIL lu_stall_after got %0h want %0h", Stall, !FWD); end
`ifndef ID_EX_FORWARDING_EN
    tick();
    checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL lu_bubble2_valid got %0h want 0", ExValid); end
    IdRs1Data = 32'hABCD;
`endif
    MemRegWrite = 1'b0; WbRd = 5'd5; WbRegWrite = 1'b1; WbData = 32'hABCD; #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL lu_stall_clear got %0h want 0", Stall); end
    tick();
    checks++; if (ExValid !== 1'b1) begin errors++; $display("FAIL lu_consumer_valid got %0h want 1", ExValid); end
    checks++; if (ExRd !== 5'd6) begin errors++; $display("FAIL lu_consumer_rd got %0d want 6", ExRd); end
    checks++; if (SrcA !== 32'hABCD) begin errors++; $display("FAIL lu_wb_srca got %0h want abcd", SrcA); end
    clear_fwd();
  endtask

  task automatic test_flush();
    set_id(1, 1, 0, 5, 32'h100, 32'h0, 32'h4, 1, 4'b0010, 1, 1, 0);
    tick();
    set_id(1, 5, 2, 6, 32'h1, 32'h2, 32'h0, 0, 4'b0010, 1, 0, 0);
    Flush = 1'b1; #1;
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL flush_stall got %0h want 1", Stall); end
    tick();
    Flush = 1'b0;
    checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0h want 0", ExValid); end
    checks++; if (ExRegWrite !== 1'b0) begin errors++; $display("FAIL flush_regwrite got %0h want 0", ExRegWrite); end
    set_id(1, 1, 2, 9, 32'h1, 32'h2, 32'h0, 0, 4'b0010, 1, 0, 0);
    tick();
    checks++; if (ExRd !== 5'd9) begin errors++; $display("FAIL hf_load_rd got %0d want 9", ExRd); end
    Hold = 1'b1; Flush = 1'b1;
    tick();
    checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL hold_flush_valid got %0h want 0", ExValid); end
    checks++; if (ExRegWrite !== 1'b0) begin errors++; $display("FAIL hold_flush_regwrite got %0h want 0", ExRegWrite); end
    Hold = 1'b0; Flush = 1'b0;
  endtask

  task automatic test_hold();
    set_id(1, 1, 0, 7, 32'h11, 32'h0, 32'h4, 1, 4'b0010, 1, 1, 0);
    tick();
    Hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 7, 7, 5'(10 + i), 32'h2000 + i, 32'h0, 32'h0, 0, 4'b0110, 1, 0, 0); #1;
      checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL hold_stall[%0d] got %0h want 0", i, Stall); end
      tick();
      checks++; if (ExRd !== 5'd7) begin errors++; $display("FAIL hold_rd[%0d] got %0d want 7", i, ExRd); end
      checks++; if (Operation !== 4'b0010) begin errors++; $display("FAIL hold_op[%0d] got %0h want 2", i, Operation); end
      checks++; if (SrcA !== 32'h11) begin errors++; $display("FAIL hold_srca[%0d] got %0h want 11", i, SrcA); end
    end
    checks++; if (ExMemRead !== 1'b1) begin errors++; $display("FAIL hold_memread got %0h want 1", ExMemRead); end
    Hold = 1'b0; #1;
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL unhold_stall got %0h want 1", Stall); end
    Hold = 1'b1; reset = 1'b0;
    tick();
    checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid got %0h want 0", ExValid); end
    checks++; if (ExMemRead !== 1'b0) begin errors++; $display("FAIL reset_hold_memread got %0h want 0", ExMemRead); end
    reset = 1'b1; Hold = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_id(1, 1, 2, 3, 32'h5, 32'h7, 32'h0, 0, 4'b0010, 1, 0, 0);
    tick();
    set_id(1, 3, 1, 4, 32'h99, 32'h5, 32'h0, 0, 4'b0010, 1, 0, 0); #1;
`ifdef ID_EX_FORWARDING_EN
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL b2b_stall got %0h want 0", Stall); end
    tick();
    MemRd = 5'd3; MemRegWrite = 1'b1; MemResult = 32'hC; #1;
    checks++; if (ExRd !== 5'd4) begin errors++; $display("FAIL b2b_rd got %0d want 4", ExRd); end
    checks++; if (SrcA !== 32'hC) begin errors++; $display("FAIL b2b_srca got %0h want c", SrcA); end
`else
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL b2b_stall1 got %0h want 1", Stall); end
    tick();
    MemRd = 5'd3; MemRegWrite = 1'b1; #1;
    checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL b2b_bubble1 got %0h want 0", ExValid); end
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL b2b_stall2 got %0h want 1", Stall); end
    tick();
    MemRegWrite = 1'b0; #1;
    checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL b2b_bubble2 got %0h want 0", ExValid); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL b2b_stall3 got %0h want 0", Stall); end
    tick();
    checks++; if (ExRd !== 5'd4) begin errors++; $display("FAIL b2b_rd got %0d want 4", ExRd); end
    checks++; if (SrcA !== 32'h99) begin errors++; $display("FAIL b2b_srca got %0h want 99", SrcA); end
`endif
    clear_fwd();
  endtask

  initial begin
    reset = 1'b0; Flush = 1'b0; Hold = 1'b0;
    clear_fwd();
    set_id(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 4'b0000, 0, 0, 0);
    #2;
    test_reset();
    test_basic();
    test_forward();
    test_zero_reg();
    test_load_use();
    test_flush();
    test_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
